tt_um_s_grundner: RTL and testbench

TT_UM_S_GRUNDNER -- requirements
Module: tt_um_s_grundner

---
 rtl/tt_um_s_grundner_pkg.sv | 22 ++
 rtl/tt_um_s_grundner_prescaler.sv | 27 ++
 rtl/tt_um_s_grundner.sv | 104 ++++++++++
 tb/tb_tt_um_s_grundner.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_s_grundner_pkg.sv
// Shared constants for the double-buffered PWM generator: widths and the
// bit positions used on the uio_in configuration and uo_out status buses.
package tt_um_s_grundner_pkg;

  localparam int CNT_W   = 8;
  localparam int PRESC_W = 7;

  localparam int LOAD  = 0;
  localparam int P_LSB = 1;
  localparam int P_MSB = 3;
  localparam int INV   = 4;

  localparam int PWM     = 0;
  localparam int PERIOD  = 1;
  localparam int PENDING = 2;

  // Mask of the low p prescaler bits that must all be ones for a tick.
  function automatic logic [PRESC_W-1:0] presc_mask(input logic [2:0] p);
    presc_mask = PRESC_W'((1 << p) - 1);
  endfunction

endpackage

// File: rtl/tt_um_s_grundner_prescaler.sv
// Free-running 7-bit prescaler; tick fires whenever the low P bits are all
// ones, so P selects a divide-by-2^P tick rate.
module pwm_prescaler
  import tt_um_s_grundner_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] p,
  output logic       tick
);

  logic [PRESC_W-1:0] presc_p0;
  logic [PRESC_W-1:0] mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_p0 <= '0;
    end else if (ena) begin
      presc_p0 <= presc_p0 + PRESC_W'(1);
    end
  end

  assign mask = presc_mask(p);
  assign tick = ((presc_p0 & mask) == mask);

endmodule

// File: rtl/tt_um_s_grundner.sv
// PWM generator with a shadowed duty register: new duty values are held
// pending and only take effect at the period boundary (cnt wraps on a tick).
module tt_um_s_grundner
  import tt_um_s_grundner_pkg::*;
#(
  parameter int CNT_W = tt_um_s_grundner_pkg::CNT_W
)
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic             tick;
  logic [2:0]       presc_sel;
  logic             step;
  logic             boundary;
  logic             load_edge;
  logic [CNT_W-1:0] cnt_p0;
  logic [CNT_W-1:0] duty_q;
  logic [CNT_W-1:0] duty_pend;
  logic             pending;
  logic             load_prev;
  logic             pwm_p1;
  logic             period_p1;
  logic [4:0]       cnt_hi_p1;
  logic             unused_cfg;

  assign presc_sel = uio_in[P_MSB:P_LSB];

  pwm_prescaler u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .p     (presc_sel),
    .tick  (tick)
  );

  assign step      = ena & tick;
  assign boundary  = step & (cnt_p0 == '1);
  assign load_edge = ena & uio_in[LOAD] & ~load_prev;

  // Stage p0: period counter and LOAD edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0    <= '0;
      load_prev <= 1'b0;
    end else if (ena) begin
      load_prev <= uio_in[LOAD];
      if (step) begin
        cnt_p0 <= cnt_p0 + CNT_W'(1);
      end
    end
  end

  // A load landing on the boundary bypasses the shadow register entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q    <= '0;
      duty_pend <= '0;
      pending   <= 1'b0;
    end else if (boundary && load_edge) begin
      duty_q  <= CNT_W'(ui_in);
      pending <= 1'b0;
    end else if (boundary && pending) begin
      duty_q  <= duty_pend;
      pending <= 1'b0;
    end else if (load_edge) begin
      duty_pend <= CNT_W'(ui_in);
      pending   <= 1'b1;
    end
  end

  // Stage p1: registered outputs, one clock behind the counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_p1    <= 1'b0;
      period_p1 <= 1'b0;
      cnt_hi_p1 <= '0;
    end else if (ena) begin
      pwm_p1    <= (cnt_p0 < duty_q) ^ uio_in[INV];
      period_p1 <= boundary;
      cnt_hi_p1 <= cnt_p0[CNT_W-1 -: 5];
    end
  end

  always_comb begin
    uo_out          = '0;
    uo_out[PWM]     = pwm_p1;
    uo_out[PERIOD]  = period_p1;
    uo_out[PENDING] = pending;
    uo_out[7:3]     = cnt_hi_p1;
  end

  assign uio_out    = '0;
  assign uio_oe     = '0;
  assign unused_cfg = &{1'b0, uio_in[7:5]};

endmodule

// File: tb/tb_tt_um_s_grundner.sv
// Scenario bench for the shadowed-duty PWM: expectations are queued before
// each stimulus window and popped when the measured DUT behaviour is ready.
module tb_tt_um_s_grundner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int   checks   = 0;
  int   failures = 0;
  int   exp_q[$];
  int   e;
  int   high;
  int   pcount;
  logic lastp;
  logic pend;
  bit   ok;

  logic [2:0] p_sel = 3'd0;
  logic       inv   = 1'b0;

  tt_um_s_grundner dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic load);
    uio_in = {3'b000, inv, p_sel, load};
  endtask

  task automatic wait_period(input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (uo_out[1]) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Runs n clocks from a period start, optionally raising LOAD at load_at for
  // hold clocks (ui_in = d on the first, ~d afterwards), and records PWM/PERIOD.
  task automatic measure(input int n, input int load_at, input int hold,
                         input logic [7:0] d);
    high = 0; pcount = 0; lastp = 1'b0; pend = 1'b0;
    for (int i = 1; i <= n; i++) begin
      if (load_at > 0 && i >= load_at && i < load_at + hold) begin
        ui_in = (i == load_at) ? d : ~d;
        set_cfg(1'b1);
      end else begin
        set_cfg(1'b0);
      end
      step();
      if (i == load_at) pend = uo_out[2];
      if (uo_out[0]) high++;
      if (uo_out[1]) pcount++;
      if (i == n) lastp = uo_out[1];
    end
    set_cfg(1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
      ena    = 1'($urandom);
      exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
      step(); step();
      checks++; e = exp_q.pop_front();
      if (uo_out !== 8'(e)) begin failures++; $display("FAIL reset_uo_out got=%h exp=%h", uo_out, e); end
      checks++; e = exp_q.pop_front();
      if (uio_out !== 8'(e)) begin failures++; $display("FAIL reset_uio_out got=%h exp=%h", uio_out, e); end
      checks++; e = exp_q.pop_front();
      if (uio_oe !== 8'(e)) begin failures++; $display("FAIL reset_uio_oe got=%h exp=%h", uio_oe, e); end
    end
    ena = 1'b1; ui_in = 8'h00; p_sel = 3'd0; inv = 1'b0; set_cfg(1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_duty();
    exp_q.push_back(1);
    wait_period(600, ok);
    checks++; e = exp_q.pop_front();
    if (int'(ok) !== e) begin failures++; $display("FAIL duty_first_period got=%0d exp=%0d", ok, e); end
    // duty 0 still active during the window in which 64 is loaded
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1);
    measure(256, 10, 1, 8'd64);
    checks++; e = exp_q.pop_front();
    if (high !== e) begin failures++; $display("FAIL duty_load_window_high got=%0d exp=%0d", high, e); end
    checks++; e = exp_q.pop_front();
    if (pend !== 1'(e)) begin failures++; $display("FAIL duty_pending got=%0d exp=%0d", pend, e); end
    checks++; e = exp_q.pop_front();
    if (lastp !== 1'(e)) begin failures++; $display("FAIL duty_period_at_256 got=%0d exp=%0d", lastp, e); end
    for (int w = 0; w < 2; w++) begin
      exp_q.push_back(64); exp_q.push_back(1); exp_q.push_back(1);
      measure(256, 0, 0, 8'd0);
      checks++; e = exp_q.pop_front();
      if (high !== e) begin failures++; $display("FAIL duty64_high got=%0d exp=%0d", high, e); end
      checks++; e = exp_q.pop_front();
      if (pcount !== e) begin failures++; $display("FAIL duty64_period_count got=%0d exp=%0d", pcount, e); end
      checks++; e = exp_q.pop_front();
      if (lastp !== 1'(e)) begin failures++; $display("FAIL duty64_period_at_256 got=%0d exp=%0d", lastp, e); end
    end
  endtask

  task automatic test_shadow();
    exp_q.push_back(64); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
    measure(256, 20, 1, 8'd200);
    checks++; e = exp_q.pop_front();
    if (high !== e) begin failures++; $display("FAIL shadow_old_duty_high got=%0d exp=%0d", high, e); end
    checks++; e = exp_q.pop_front();
    if (pend !== 1'(e)) begin failures++; $display("FAIL shadow_pending_set got=%0d exp=%0d", pend, e); end
    checks++; e = exp_q.pop_front();
    if (lastp !== 1'(e)) begin failures++; $display("FAIL shadow_period got=%0d exp=%0d", lastp, e); end
    checks++; e = exp_q.pop_front();
    if (uo_out[2] !== 1'(e)) begin failures++; $display("FAIL shadow_pending_clear got=%0d exp=%0d", uo_out[2], e); end
    exp_q.push_back(200);
    measure(256, 0, 0, 8'd0);
    checks++; e = exp_q.pop_front();
    if (high !== e) begin failures++; $display("FAIL shadow_new_duty_high got=%0d exp=%0d", high, e); end
  endtask

  task automatic test_prescaler();
    p_sel = 3'd2; set_cfg(1'b0);
    exp_q.push_back(1);
    wait_period(1100, ok);
    checks++; e = exp_q.pop_front();
    if (int'(ok) !== e) begin failures++; $display("FAIL presc_sync got=%0d exp=%0d", ok, e); end
    exp_q.push_back(800); exp_q.push_back(1); exp_q.push_back(1);
    measure(1024, 10, 1, 8'd128);
    checks++; e = exp_q.pop_front();
    if (high !== e) begin failures++; $display("FAIL presc_old_high got=%0d exp=%0d", high, e); end
    checks++; e = exp_q.pop_front();
    if (pend !== 1'(e)) begin failures++; $display("FAIL presc_pending got=%0d exp=%0d", pend, e); end
    checks++; e = exp_q.pop_front();
    if (lastp !== 1'(e)) begin failures++; $display("FAIL presc_period_at_1024 got=%0d exp=%0d", lastp, e); end
    exp_q.push_back(512); exp_q.push_back(1); exp_q.push_back(1);
    measure(1024, 0, 0, 8'd0);
    checks++; e = exp_q.pop_front();
    if (high !== e) begin failures++; $display("FAIL presc_high got=%0d exp=%0d", high, e); end
    checks++; e = exp_q.pop_front();
    if (pcount !== e) begin failures++; $display("FAIL presc_period_count got=%0d exp=%0d", pcount, e); end
    checks++; e = exp_q.pop_front();
    if (lastp !== 1'(e)) begin failures++; $display("FAIL presc_period_interval got=%0d exp=%0d", lastp, e); end
  endtask

  task automatic test_edges();
    p_sel = 3'd0; set_cfg(1'b0);
    exp_q.push_back(1);
    wait_period(600, ok);
    checks++; e = exp_q.pop_front();
    if (int'(ok) !== e) begin failures++; $display("FAIL edge_sync got=%0d exp=%0d", ok, e); end
    measure(256, 10, 1, 8'd0);
    exp_q.push_back(0);
    measure(256, 0, 0, 8'd0);
    checks++; e = exp_q.pop_front();
    if (high !== e) begin failures++; $display("FAIL edge_d0_high got=%0d exp=%0d", high, e); end
    inv = 1'b1;
    exp_q.push_back(256);
    measure(256, 10, 1, 8'd255);
    checks++; e = exp_q.pop_front();
    if (high !== e) begin failures++; $display("FAIL edge_d0_inv_high got=%0d exp=%0d", high, e); end
    exp_q.push_back(1);
    measure(256, 0, 0, 8'd0);
    checks++; e = exp_q.pop_front();
    if (high !== e) begin failures++; $display("FAIL edge_d255_inv_high got=%0d exp=%0d", high, e); end
    inv = 1'b0;
    exp_q.push_back(255); exp_q.push_back(1);
    measure(256, 10, 10, 8'd30);
    checks++; e = exp_q.pop_front();
    if (high !== e) begin failures++; $display("FAIL edge_d255_high got=%0d exp=%0d", high, e); end
    checks++; e = exp_q.pop_front();
    if (pend !== 1'(e)) begin failures++; $display("FAIL edge_hold_pending got=%0d exp=%0d", pend, e); end
    exp_q.push_back(30);
    measure(256, 0, 0, 8'd0);
    checks++; e = exp_q.pop_front();
    if (high !== e) begin failures++; $display("FAIL edge_hold_single_capture got=%0d exp=%0d", high, e); end
  endtask

  task automatic test_enable_reset();
    exp_q.push_back(30);
    measure(256, 10, 1, 8'd100);
    checks++; e = exp_q.pop_front();
    if (high !== e) begin failures++; $display("FAIL ena_pre_high got=%0d exp=%0d", high, e); end
    for (int i = 0; i < 100; i++) step();
    // cnt was 99 before the last edge: cnt[7:3]=12, PWM=(99<100)
    exp_q.push_back(8'h61); exp_q.push_back(8'h61); exp_q.push_back(8'h61);
    checks++; e = exp_q.pop_front();
    if (uo_out !== 8'(e)) begin failures++; $display("FAIL ena_before got=%h exp=%h", uo_out, e); end
    ena = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      if (i == 10) begin ui_in = 8'd7; set_cfg(1'b1); end
      step();
      if (i == 1 || i == 50) begin
        checks++; e = exp_q.pop_front();
        if (uo_out !== 8'(e)) begin failures++; $display("FAIL ena_frozen_%0d got=%h exp=%h", i, uo_out, e); end
      end
    end
    exp_q.push_back(8'h64);
    ena = 1'b1;
    step();
    checks++; e = exp_q.pop_front();
    if (uo_out !== 8'(e)) begin failures++; $display("FAIL ena_resume_edge got=%h exp=%h", uo_out, e); end
    set_cfg(1'b0);
    step(); step(); step();
    exp_q.push_back(0); exp_q.push_back(0);
    #2 rst_n = 1'b0;
    #1;
    checks++; e = exp_q.pop_front();
    if (uo_out !== 8'(e)) begin failures++; $display("FAIL async_reset_uo_out got=%h exp=%h", uo_out, e); end
    checks++; e = exp_q.pop_front();
    if (dut.cnt_p0 !== 8'(e)) begin failures++; $display("FAIL async_reset_cnt got=%h exp=%h", dut.cnt_p0, e); end
    step(); step();
    rst_n = 1'b1;
    exp_q.push_back(8'h10);
    for (int i = 0; i < 17; i++) step();
    checks++; e = exp_q.pop_front();
    if (uo_out !== 8'(e)) begin failures++; $display("FAIL post_reset_count got=%h exp=%h", uo_out, e); end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    test_reset();
    test_duty();
    test_shadow();
    test_prescaler();
    test_edges();
    test_enable_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
